// File: rtl/aes_ctr_pkg.sv
// ============================================================================
// Module      : aes_ctr_pkg
// Description : Shared widths, jitter constants and FSM encoding for the
//               AES-CTR block sequencer and its optional step-jitter unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_ctr_pkg;

  localparam int AES_BLK_W        = 128;
  localparam int AES_CTR_W        = 32;
  localparam int AES_NONCE_W      = AES_BLK_W - AES_CTR_W;

  localparam int JITTER_LFSR_W    = 16;
  localparam int JITTER_STALL_W   = 2;
  localparam int JITTER_MAX_STALL = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/aes_ctr_ctrl_jitter.sv
// ============================================================================
// Module      : aes_step_jitter
// Description : Pseudo-random round-advance enable for the AES core.
//               16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every
//               cycle; step_en drops when lfsr[1:0]==0, but never for more
//               than JITTER_MAX_STALL consecutive cycles.
// Ports       : clk, rst (sync, active-high) ; step_en out
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_step_jitter
  import aes_ctr_pkg::*;
#(
  parameter logic [JITTER_LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  output logic step_en
);

  logic [JITTER_LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [JITTER_STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // The stall counter overrides the LFSR so the core can never starve.
    step_en = (lfsr_q[1:0] != 2'b00) ||
              (stall_q == JITTER_STALL_W'(JITTER_MAX_STALL));
    stall_d = step_en ? '0 : stall_q + JITTER_STALL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= SEED;
      stall_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      stall_q <= stall_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_ctr_ctrl.sv
// ============================================================================
// Module      : aes_ctr_ctrl
// Description : CTR-mode block sequencer in front of an iterative AES-128
//               core. Accepts data blocks, issues {nonce, ctr} to the core,
//               XORs the returned keystream with the data and emits it.
// Ports       : clk/rst ; cfg_load/cfg_key/cfg_iv ; in_* stream ; out_*
//               stream ; core_* interface ; keyed, ctr_wrap status.
// Build macro : AES_CTR_JITTER_EN - randomised core_step_en via
//               aes_step_jitter; undefined ties core_step_en to 1.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_ctr_ctrl
  import aes_ctr_pkg::*;
#(
  parameter logic [15:0] JITTER_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [AES_BLK_W-1:0] cfg_key,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 out_last,
  output logic                 core_start,
  output logic [AES_BLK_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_plaintext,
  output logic                 core_step_en,
  input  logic                 core_busy,
  input  logic                 core_done,
  input  logic [AES_BLK_W-1:0] core_ciphertext,
  output logic                 keyed,
  output logic                 ctr_wrap
);

  state_e                   state_q, state_d;
  logic [AES_BLK_W-1:0]     key_q, key_d;
  logic [AES_NONCE_W-1:0]   nonce_q, nonce_d;
  logic [AES_CTR_W-1:0]     ctr_q, ctr_d;
  logic [AES_BLK_W-1:0]     pt_q, pt_d;
  logic [AES_BLK_W-1:0]     data_q, data_d;
  logic                     last_q, last_d;
  logic [AES_BLK_W-1:0]     out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic                     keyed_q, keyed_d;
  logic                     wrap_q, wrap_d;
  logic [AES_NONCE_W-1:0]   nonce_sel;
  logic [AES_CTR_W-1:0]     ctr_sel;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    ctr_d      = ctr_q;
    pt_d       = pt_q;
    data_d     = data_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    keyed_d    = keyed_q;
    wrap_d     = wrap_q;
    // A block accepted in the same cycle as a reload uses the new IV.
    nonce_sel  = cfg_load ? cfg_iv[AES_BLK_W-1:AES_CTR_W] : nonce_q;
    ctr_sel    = cfg_load ? cfg_iv[AES_CTR_W-1:0]         : ctr_q;

    if (cfg_load && (state_q == ST_IDLE || state_q == ST_READY)) begin
      key_d   = cfg_key;
      nonce_d = cfg_iv[AES_BLK_W-1:AES_CTR_W];
      ctr_d   = cfg_iv[AES_CTR_W-1:0];
      wrap_d  = 1'b0;
      keyed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_load) state_d = ST_READY;
      end
      ST_READY: begin
        if (in_valid) begin
          // Counter block is captured here so the core sees a value that
          // stays put while ctr itself advances in ISSUE.
          pt_d    = {nonce_sel, ctr_sel};
          data_d  = in_data;
          last_d  = in_last;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ctr_d   = ctr_q + AES_CTR_W'(1);
        if (&ctr_q) wrap_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          out_data_d = core_ciphertext ^ data_q;
          out_last_d = last_q;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = wrap_q ? ST_IDLE : ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      nonce_q    <= '0;
      ctr_q      <= '0;
      pt_q       <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      keyed_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      ctr_q      <= ctr_d;
      pt_q       <= pt_d;
      data_q     <= data_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      keyed_q    <= keyed_d;
      wrap_q     <= wrap_d;
    end
  end

  assign in_ready       = (state_q == ST_READY);
  assign out_valid      = (state_q == ST_OUT);
  assign core_start     = (state_q == ST_ISSUE);
  assign core_key       = key_q;
  assign core_plaintext = pt_q;
  assign out_data       = out_data_q;
  assign out_last       = out_last_q;
  assign keyed          = keyed_q;
  assign ctr_wrap       = wrap_q;

  // Sequencing relies on core_done alone; busy is informational.
  logic unused_core_busy;
  assign unused_core_busy = core_busy;

`ifdef AES_CTR_JITTER_EN
  aes_step_jitter #(
    .SEED    (JITTER_SEED)
  ) u_jitter (
    .clk     (clk),
    .rst     (rst),
    .step_en (core_step_en)
  );
`else
  assign core_step_en = 1'b1;
  logic [15:0] unused_jitter_seed;
  assign unused_jitter_seed = JITTER_SEED;
`endif

endmodule

`default_nettype wire
